// File: rtl/clock_set_ctrl.sv
// Mode/time-set sequencer: turns buttons and the 1 Hz strobe into inc_sec/min/hour
// enables, blink mask and day-advance pulse. All outputs registered, one cycle latency.
module clock_set_ctrl #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int IDLE_TIMEOUT  = 10
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       tick_1Hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_inc_lvl,
   input  logic       end_of_day,
   output logic       inc_sec,
   output logic       inc_min,
   output logic       inc_hour,
   output logic       day_inc,
   output logic [1:0] mode,
   output logic [2:0] blink_mask
);

   localparam int RW = $clog2(REPEAT_DELAY + 1);
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } mode_t;

   mode_t         r_mode;
   logic [RW-1:0] r_rep_cnt;
   logic [IW-1:0] r_idle;
   logic          r_phase;

   logic          w_set;
   logic          w_activity;
   logic [RW-1:0] w_rep_cnt_inc;
   logic          w_rep_evt;
   logic          w_timeout;
   logic          w_mode_chg;
   mode_t         w_mode_nxt;
   logic          w_inc_evt;
   logic          w_phase_nxt;
   logic [2:0]    w_mask_nxt;

   assign w_set         = (r_mode != RUN);
   assign w_activity    = btn_mode | btn_inc | btn_inc_lvl;
   assign w_rep_cnt_inc = r_rep_cnt + 1'b1;
   assign w_rep_evt     = w_set && btn_inc_lvl && (w_rep_cnt_inc == RW'(REPEAT_DELAY));
   // Timeout looks only at the stored count, so a same-cycle btn_mode cannot mask it.
   assign w_timeout     = w_set && tick_1Hz && (r_idle >= IW'(IDLE_TIMEOUT - 1));
   assign w_mode_chg    = w_timeout | btn_mode;
   assign w_inc_evt     = w_set && !w_mode_chg && (btn_inc || w_rep_evt);

   always_comb begin
      w_mode_nxt = r_mode;
      if (w_timeout)
         w_mode_nxt = RUN;
      else if (btn_mode)
         w_mode_nxt = mode_t'(r_mode + 2'd1);
   end

   always_comb begin
      w_phase_nxt = r_phase;
      if (w_mode_chg && (w_mode_nxt == RUN))
         w_phase_nxt = 1'b0;
      else if (w_inc_evt)
         w_phase_nxt = 1'b1;
      else if (tick_1Hz)
         w_phase_nxt = ~r_phase;
   end

   always_comb begin
      w_mask_nxt = 3'b000;
      case (w_mode_nxt)
         SET_HOUR: w_mask_nxt = {w_phase_nxt, 2'b00};
         SET_MIN:  w_mask_nxt = {1'b0, w_phase_nxt, 1'b0};
         SET_SEC:  w_mask_nxt = {2'b00, w_phase_nxt};
         default:  w_mask_nxt = 3'b000;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_mode     <= RUN;
         r_rep_cnt  <= '0;
         r_idle     <= '0;
         r_phase    <= 1'b0;
         inc_sec    <= 1'b0;
         inc_min    <= 1'b0;
         inc_hour   <= 1'b0;
         day_inc    <= 1'b0;
         mode       <= 2'd0;
         blink_mask <= 3'b000;
      end else begin
         r_mode  <= w_mode_nxt;
         r_phase <= w_phase_nxt;

         if (!w_set || !btn_inc_lvl || w_mode_chg)
            r_rep_cnt <= '0;
         else if (w_rep_evt)
            r_rep_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
         else
            r_rep_cnt <= w_rep_cnt_inc;

         if (!w_set || w_mode_chg || w_activity)
            r_idle <= '0;
         else if (tick_1Hz && (r_idle < IW'(IDLE_TIMEOUT)))
            r_idle <= r_idle + 1'b1;

         inc_sec    <= ((r_mode == RUN) && tick_1Hz) || ((r_mode == SET_SEC) && w_inc_evt);
         inc_min    <= (r_mode == SET_MIN) && w_inc_evt;
         inc_hour   <= (r_mode == SET_HOUR) && w_inc_evt;
         day_inc    <= (r_mode == RUN) && tick_1Hz && end_of_day;
         mode       <= w_mode_nxt;
         blink_mask <= w_mask_nxt;
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

   localparam int D = 8;
   localparam int P = 3;
   localparam int T = 4;

   logic       clk = 1'b0;
   logic       reset, tick_1Hz, btn_mode, btn_inc, btn_inc_lvl, end_of_day;
   logic       inc_sec, inc_min, inc_hour, day_inc;
   logic [1:0] mode;
   logic [2:0] blink_mask;

   clock_set_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .IDLE_TIMEOUT(T)) dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .tick_1Hz   (tick_1Hz),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .btn_inc_lvl(btn_inc_lvl),
      .end_of_day (end_of_day),
      .inc_sec    (inc_sec),
      .inc_min    (inc_min),
      .inc_hour   (inc_hour),
      .day_inc    (day_inc),
      .mode       (mode),
      .blink_mask (blink_mask)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   // reference state: mode, idle tick count, length of current in-SET hold, blink phase
   int m_mode, m_idle, m_hold;
   bit m_phase;
   bit e_sec, e_min, e_hour, e_day;
   int e_mode;
   int e_mask;

   int n_sec, n_min, n_hour, n_day;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
      end
   endtask

   task automatic model_step();
      bit set, rep, tmo, chg, inc, act;
      int hold_new, nmode;
      if (reset) begin
         m_mode = 0; m_idle = 0; m_hold = 0; m_phase = 0;
         e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_mode = 0; e_mask = 0;
         return;
      end
      set      = (m_mode != 0);
      act      = btn_mode | btn_inc | btn_inc_lvl;
      hold_new = (set && btn_inc_lvl) ? m_hold + 1 : 0;
      rep      = (hold_new >= D) && ((hold_new - D) % P == 0);
      tmo      = set && tick_1Hz && (m_idle >= T - 1);
      chg      = tmo || btn_mode;
      nmode    = tmo ? 0 : (btn_mode ? (m_mode + 1) % 4 : m_mode);
      inc      = set && !chg && (btn_inc || rep);
      e_sec    = (m_mode == 0 && tick_1Hz) || (m_mode == 3 && inc);
      e_min    = (m_mode == 2 && inc);
      e_hour   = (m_mode == 1 && inc);
      e_day    = (m_mode == 0 && tick_1Hz && end_of_day);
      if (chg && nmode == 0)  m_phase = 0;
      else if (inc)           m_phase = 1;
      else if (tick_1Hz)      m_phase = ~m_phase;
      if (!set || chg || act) m_idle = 0;
      else if (tick_1Hz)      m_idle = (m_idle + 1 > T) ? T : m_idle + 1;
      m_hold = chg ? 0 : hold_new;
      m_mode = nmode;
      e_mode = nmode;
      case (nmode)
         1:       e_mask = m_phase ? 4 : 0;
         2:       e_mask = m_phase ? 2 : 0;
         3:       e_mask = m_phase ? 1 : 0;
         default: e_mask = 0;
      endcase
   endtask

   task automatic cyc(input bit rs, input bit tk, input bit bm, input bit bi,
                      input bit bl, input bit eod);
      reset = rs; tick_1Hz = tk; btn_mode = bm; btn_inc = bi;
      btn_inc_lvl = bl; end_of_day = eod;
      @(posedge clk);
      model_step();
      @(negedge clk);
      cycle++;
      chk("inc_sec", inc_sec, e_sec);
      chk("inc_min", inc_min, e_min);
      chk("inc_hour", inc_hour, e_hour);
      chk("day_inc", day_inc, e_day);
      chk("mode", mode, e_mode);
      chk("blink_mask", blink_mask, e_mask);
      n_sec  += inc_sec;
      n_min  += inc_min;
      n_hour += inc_hour;
      n_day  += day_inc;
   endtask

   task automatic clr_tally();
      n_sec = 0; n_min = 0; n_hour = 0; n_day = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit rs, tk, bm, bi, bl, eod;
      reset = 1; tick_1Hz = 0; btn_mode = 0; btn_inc = 0; btn_inc_lvl = 0; end_of_day = 0;
      @(negedge clk);
      do_reset();
      chk("reset_mode", mode, 0);
      chk("reset_mask", blink_mask, 0);

      // 1: ticks in RUN
      clr_tally();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         chk("t1_sec_after_tick", inc_sec, 1);
         idle(2);
      end
      chk("t1_sec_count", n_sec, 3);
      chk("t1_min_hour", n_min + n_hour, 0);

      // 2: set minutes by hand
      do_reset();
      clr_tally();
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 1, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
      end
      chk("t2_mode", mode, 2);
      chk("t2_min_count", n_min, 5);
      chk("t2_sec_hour", n_sec + n_hour, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("t2_back_run", mode, 0);

      // 3: auto-repeat in SET_HOUR
      do_reset();
      cyc(0, 0, 1, 0, 0, 0);
      clr_tally();
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 0, 0, 0, 1, 0);
         chk("t3_repeat_slot", inc_hour, (i >= 8 && (i - 8) % 3 == 0));
      end
      chk("t3_hour_count", n_hour, 5);
      idle(10);
      chk("t3_after_release", n_hour, 5);

      // 4: idle timeout from SET_SEC
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
      chk("t4_mode_sec", mode, 3);
      for (int k = 1; k <= 4; k++) begin
         cyc(0, 1, 0, 0, 0, 0);
         if (k < 4) chk("t4_blink_sec", blink_mask, (k % 2));
         else       chk("t4_timeout_mode", mode, 0);
         idle(2);
      end

      // 5: day rollover only in RUN
      do_reset();
      clr_tally();
      cyc(0, 1, 0, 0, 0, 1);
      idle(1);
      chk("t5_day_run", n_day, 1);
      chk("t5_sec_run", n_sec, 1);
      cyc(0, 0, 1, 0, 0, 0);
      clr_tally();
      cyc(0, 1, 0, 0, 0, 1);
      idle(1);
      chk("t5_day_set", n_day, 0);

      // 6: mode beats inc; reset mid-SET
      do_reset();
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      clr_tally();
      cyc(0, 0, 1, 1, 0, 0);
      chk("t6_mode", mode, 3);
      chk("t6_no_min", n_min, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("t6_reset_mode", mode, 0);
      chk("t6_reset_outs", {inc_sec, inc_min, inc_hour, day_inc, blink_mask}, 0);

      // randomized traffic against the model
      bl = 0;
      for (int i = 0; i < 4000; i++) begin
         rs  = ($urandom_range(0, 499) == 0);
         tk  = ($urandom_range(0, 7) == 0);
         bm  = ($urandom_range(0, 24) == 0);
         bi  = ($urandom_range(0, 9) == 0);
         eod = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 14) == 0) bl = ~bl;
         cyc(rs, tk, bm, bi, bl, eod);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
